// File: rtl/decrypt_loop_if.sv
// Block stream interface of decrypt_loop: ciphertext in, plaintext out, no backpressure on the result side.
interface decrypt_loop_if;
  logic [639:0] in;
  logic         read;
  logic         in_ready;
  logic [639:0] out;
  logic         write;
  logic         busy;

  modport master (output in, read, input in_ready, out, write, busy);
  modport slave  (input in, read, output in_ready, out, write, busy);
endinterface

// File: rtl/decrypt_loop.sv
// Four-slot circulating decrypt ring: each slot applies one inverse full round per cycle,
// blocks loop PASSES times with the keys in reverse encrypt order, then retire to out.
module inv_full_round (
  input  logic         clk,
  input  logic [19:0]  roundkey,
  input  logic [639:0] in,
  output logic [639:0] out
);
  localparam int NUM_WORDS = 32;
  localparam int WORD_W    = 20;

  logic [WORD_W-1:0] t, d;

  // Undo the forward word rotation, subtract the key, rotate right 3, strip the key.
  always_comb begin
    out = '0;
    t   = '0;
    d   = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      t = in[((i + 1) % NUM_WORDS) * WORD_W +: WORD_W];
      d = t - roundkey;
      out[i*WORD_W +: WORD_W] = {d[2:0], d[WORD_W-1:3]} ^ roundkey;
    end
  end

  key_known: assert property (@(posedge clk) !$isunknown(roundkey));
endmodule

module decrypt_loop #(
  parameter int          PASSES = 1,
  parameter logic [19:0] KEY0   = 20'hFEDCB,
  parameter logic [19:0] KEY1   = 20'hABCDE,
  parameter logic [19:0] KEY2   = 20'h67890,
  parameter logic [19:0] KEY3   = 20'h12345
) (
  input logic          clk,
  input logic          rst,
  decrypt_loop_if.slave bus
);
  localparam int STAGES = 4;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0]            CNT_LAST = CW'(PASSES - 1);
  localparam logic [STAGES-1:0][19:0]  KEYS     = {KEY3, KEY2, KEY1, KEY0};

  logic [STAGES-1:0][639:0]  state, nxt;
  logic [STAGES-1:0]         vld;
  logic [STAGES-1:0][CW-1:0] cnt;
  logic [639:0]              res;
  logic                      wr, bsy;
  logic                      last, recirc, inject, fill;

  genvar s;
  for (s = 0; s < STAGES; s++) begin : g_stage
    inv_full_round u_round (
      .clk      (clk),
      .roundkey (KEYS[s]),
      .in       (state[s]),
      .out      (nxt[s])
    );
  end

  always_comb begin
    last   = vld[3] && (cnt[3] == CNT_LAST);
    recirc = vld[3] && !last;
    inject = !recirc && bus.read;
    fill   = recirc || inject;
  end

  assign bus.in_ready = !recirc;
  assign bus.out      = res;
  assign bus.write    = wr;
  assign bus.busy     = bsy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      cnt <= '0;
      res <= '0;
      wr  <= 1'b0;
      bsy <= 1'b0;
    end else begin
      vld        <= {vld[2:0], fill};
      cnt[3:1]   <= cnt[2:0];
      cnt[0]     <= recirc ? cnt[3] + CW'(1) : '0;
      wr         <= last;
      bsy        <= |{vld[2:0], fill};
      if (last) res <= nxt[3];
    end
  end

  // Slot data carries no reset; only the valid bits decide what is live.
  always_ff @(posedge clk) begin
    state[3:1] <= nxt[2:0];
    if (recirc)      state[0] <= nxt[3];
    else if (inject) state[0] <= bus.in;
  end
endmodule

// File: tb/tb_decrypt_loop.sv
// Directed bench for decrypt_loop: ciphertexts are built with a forward round model, outputs must match plaintexts.
module tb_decrypt_loop;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decrypt_loop_if b1 ();
  decrypt_loop_if b2 ();
  decrypt_loop_if b3 ();

  decrypt_loop #(.PASSES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  decrypt_loop #(.PASSES(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  decrypt_loop #(.PASSES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  // Encrypt key order: first encrypt key is KEY3.
  logic [19:0] fkeys [4] = '{20'h12345, 20'h67890, 20'hABCDE, 20'hFEDCB};

  function automatic logic [639:0] fround(logic [639:0] x, logic [19:0] k);
    logic [19:0]  t [32];
    logic [19:0]  v;
    logic [639:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      v    = x[i*20 +: 20] ^ k;
      t[i] = {v[16:0], v[19:17]} + k;
    end
    for (int i = 0; i < 32; i++) y[i*20 +: 20] = t[(i + 31) % 32];
    return y;
  endfunction

  function automatic logic [639:0] enc(logic [639:0] p, int passes);
    logic [639:0] x;
    x = p;
    for (int n = 0; n < passes; n++)
      for (int s = 0; s < 4; s++) x = fround(x, fkeys[s]);
    return x;
  endfunction

  task automatic chk(string tag, logic [639:0] got, logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int sel, logic [639:0] d, logic r);
    case (sel)
      1: begin b1.in = d; b1.read = r; end
      2: begin b2.in = d; b2.read = r; end
      default: begin b3.in = d; b3.read = r; end
    endcase
  endtask

  function automatic logic get_ready(int sel);
    case (sel)
      1: return b1.in_ready;
      2: return b2.in_ready;
      default: return b3.in_ready;
    endcase
  endfunction

  function automatic logic get_write(int sel);
    case (sel)
      1: return b1.write;
      2: return b2.write;
      default: return b3.write;
    endcase
  endfunction

  function automatic logic get_busy(int sel);
    case (sel)
      1: return b1.busy;
      2: return b2.busy;
      default: return b3.busy;
    endcase
  endfunction

  function automatic logic [639:0] get_out(int sel);
    case (sel)
      1: return b1.out;
      2: return b2.out;
      default: return b3.out;
    endcase
  endfunction

  // Five blocks offered back to back into a PASSES=p ring: four fill the ring, the fifth
  // waits until the first retires at 4p, then comes out at 8p.
  task automatic occ(int sel, int p, logic [639:0] base, logic [639:0] out0);
    int           idx;
    int           k;
    logic         rdy;
    logic         r;
    logic [639:0] eo;
    idx = 0;
    eo  = out0;
    for (int t = 0; t <= 8*p + 3; t++) begin
      if (idx < 5) set_in(sel, enc(base + 640'(idx), p), 1'b1);
      else         set_in(sel, '0, 1'b0);
      rdy = get_ready(sel);
      if (t <= 4*p) chk($sformatf("occ%0d_rdy%0d", p, t), 640'(rdy), 640'((t < 4) || (t == 4*p)));
      if (idx < 5 && rdy) idx++;
      tick();
      r = ((t >= 4*p) && (t <= 4*p + 3)) || (t == 8*p);
      if (r) begin
        k  = (t == 8*p) ? 4 : t - 4*p;
        eo = base + 640'(k);
      end
      chk($sformatf("occ%0d_wr%0d", p, t), 640'(get_write(sel)), 640'(r));
      chk($sformatf("occ%0d_out%0d", p, t), get_out(sel), eo);
    end
    chk($sformatf("occ%0d_accepted", p), 640'(idx), 640'(5));
    set_in(sel, '0, 1'b0);
    tick();
    tick();
    chk($sformatf("occ%0d_drained", p), 640'(get_busy(sel)), 640'(0));
  endtask

  initial begin
    for (int s = 1; s <= 3; s++) set_in(s, '0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();

    // Reset pulse with no stimulus, then idle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int s = 1; s <= 3; s++) begin
        chk($sformatf("idle_out%0d_%0d", s, c), get_out(s), '0);
        chk($sformatf("idle_wr%0d_%0d", s, c), 640'(get_write(s)), 640'(0));
        chk($sformatf("idle_busy%0d_%0d", s, c), 640'(get_busy(s)), 640'(0));
        chk($sformatf("idle_rdy%0d_%0d", s, c), 640'(get_ready(s)), 640'(1));
      end
      tick();
    end

    // Single round trip, PASSES=1.
    set_in(1, enc(640'h1, 1), 1'b1);
    chk("rt_rdy", 640'(b1.in_ready), 640'(1));
    tick();
    set_in(1, '0, 1'b0);
    chk("rt_busy", 640'(b1.busy), 640'(1));
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("rt_wr%0d", k), 640'(b1.write), 640'(k == 4));
      if (k == 4) chk("rt_out", b1.out, 640'h1);
    end

    // Streaming 1..8, PASSES=1.
    for (int t = 0; t < 14; t++) begin
      if (t < 8) begin
        set_in(1, enc(640'(t + 1), 1), 1'b1);
        chk($sformatf("st_rdy%0d", t), 640'(b1.in_ready), 640'(1));
      end else begin
        set_in(1, '0, 1'b0);
      end
      tick();
      chk($sformatf("st_wr%0d", t), 640'(b1.write), 640'((t >= 4) && (t <= 11)));
      if (t >= 4 && t <= 11) chk($sformatf("st_out%0d", t), b1.out, 640'(t - 3));
    end
    tick();
    chk("st_out_hold", b1.out, 640'h8);

    // Reset mid-flight, PASSES=2.
    for (int t = 0; t < 3; t++) begin
      set_in(2, enc(640'(8'h30 + t), 2), 1'b1);
      chk($sformatf("rm_rdy%0d", t), 640'(b2.in_ready), 640'(1));
      tick();
    end
    set_in(2, '0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rm_busy", 640'(b2.busy), 640'(0));
    chk("rm_wr", 640'(b2.write), 640'(0));
    chk("rm_out", b2.out, '0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("rm_quiet%0d", c), 640'(b2.write), 640'(0));
    end
    set_in(2, enc(640'h55, 2), 1'b1);
    tick();
    set_in(2, '0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("rm_wr%0d", k), 640'(b2.write), 640'(k == 8));
      if (k == 8) chk("rm_out_new", b2.out, 640'h55);
    end

    // Held offer while the ring is full, PASSES=2; then occupancy with PASSES=3.
    occ(2, 2, 640'h100, 640'h55);
    occ(3, 3, 640'hA, 640'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decrypt_loop.md
Name: decrypt_loop

Overview:
Inverse of the four-stage encrypt ring: takes a 640-bit ciphertext block and applies inverse full rounds with the round keys in reverse order. It returns the original 640-bit plaintext. The block is a four-slot circulating pipeline, so up to four independent blocks can be in flight at once. It sits after encrypt_loop in the miner datapath and provides self-check and round-trip verification.

Parameters:
PASSES, 1, number of full trips around the 4-stage ring per block (total inverse rounds = 4*PASSES); must be >= 1
KEY0, 20'hFEDCB, round key used by stage 0 (the last encrypt key)
KEY1, 20'hABCDE, round key for stage 1
KEY2, 20'h67890, round key for stage 2
KEY3, 20'h12345, round key for stage 3 (the first encrypt key)

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in  input  640  ciphertext block
read  input  1  offer of `in`; the block is accepted on a cycle where read && in_ready
in_ready  output  1  combinational; slot 0 can take a new block this cycle
out  output  640  registered plaintext result
write  output  1  registered one-cycle strobe; `out` is valid
busy  output  1  registered OR of all four slot-valid bits

Behaviour:
- Ring of four slots, s = 0..3. Each slot holds:
  - state[s], 640 bits
  - vld[s]
  - cnt[s], passes completed, width max(1, clog2(PASSES))
- Four inv_full_round instances, each with ports (clk, roundkey, in, out):
  - stage s has in = state[s] and roundkey = KEYs, and produces nxt[s].
  - Each instance is combinational from in to out; the clk port is tied but adds no latency.
- Every rising edge:
  - state[1..3] <= nxt[0..2], and vld/cnt shift along with the data.
  - `last` = vld[3] && cnt[3] == PASSES-1.
  - If `last`: out <= nxt[3] and write <= 1. Slot 0 is then free.
  - If not `last`: write <= 0.
  - If vld[3] && !last: state[0] <= nxt[3], vld[0] <= 1, cnt[0] <= cnt[3]+1. This is recirculation.
  - Else if read && in_ready: state[0] <= in, vld[0] <= 1, cnt[0] <= 0. This is injection.
  - Else: vld[0] <= 0, and state[0] holds its previous value.
- Handshakes:
  - in_ready = !vld[3] || last.
  - Recirculation always wins over injection.
  - `read` with in_ready low is ignored. The source must hold `in` stable until it is accepted.
- Output:
  - No backpressure. write pulses for exactly one cycle per completed block.
  - `out` holds its last value between pulses.
- Latency:
  - A block accepted at edge E produces write = 1 and its `out` value after edge E + 4*PASSES.
  - Completion order equals acceptance order.
- Throughput:
  - PASSES = 1: one block per cycle, sustained.
  - PASSES = N: each slot is occupied for N trips around the ring. New blocks enter only as slots retire, giving an average of 1 block per N cycles.
- Simultaneous retire and accept: in the same edge, `out` takes the retiring block and state[0] takes `in`.
- Wrap-around: cnt never exceeds PASSES-1. With PASSES = 1, cnt is constant 0 and every vld[3] is `last`.
- Reset:
  - Asserting rst at any time (including mid-operation) immediately clears all vld, cnt, write and busy, and sets `out` to 0.
  - state[] contents are don't-care after reset.
  - In-flight blocks are discarded and never emitted.
  - The first edge after release may accept input.
- busy = 0 implies the ring is empty and the first subsequent `out` will come from a newly accepted block.

Test Plan:
1. Reset then idle: rst pulsed mid-sim with no stimulus -> out = 0, write = 0, busy = 0, in_ready = 1 on every cycle.
2. PASSES=1 round trip:
   - Take the encrypt_loop output for plaintext 640'h1 and feed it with a single-cycle read at edge E.
   - Expected: write = 1 exactly at E+4, out = 640'h1, and write = 0 at E+1..E+3 and E+5.
3. PASSES=1 streaming:
   - Feed ciphertexts of plaintexts 1..8 on consecutive cycles.
   - Expected: in_ready stays 1 throughout; write is high for 8 consecutive cycles starting 4 cycles after the first accept; out = 1..8 in order.
4. PASSES=3 occupancy:
   - Hold read high with ciphertexts of 0xA, 0xB, 0xC, 0xD, 0xE.
   - Expected: the first four are accepted on 4 consecutive cycles, then in_ready = 0 for 8 cycles.
   - The fifth block is accepted on the same edge that 0xA retires (at accept+12), and out = 0xA..0xE in order.
5. Reset mid-flight: PASSES=2, accept 3 blocks, assert rst 2 cycles later.
   - Expected: none of those blocks ever produces write; busy = 0 immediately.
   - A block accepted after release returns correctly 8 cycles later.
6. Non-accept: read = 1 while in_ready = 0 (PASSES=2, ring full).
   - Expected: the offered block is not lost; it is accepted when in_ready rises and appears 8 cycles after that accept.
